// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
//   Shares one combinational instruction memory among NUM_CORES fetch stages.
//   Round-robin arbitration in cycle T, registered address toward memory in
//   T+1, registered response (one-hot per-core strobe) in T+2. One fetch per
//   cycle, no backpressure. A per-core flush kills that core's same-cycle
//   request and its stage-1 entry.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_req         : per-core fetch request level
//   i_req_addr    : per-core byte address, core i at [32*i+31:32*i]
//   i_flush       : per-core kill of same-cycle / in-flight fetch
//   o_gnt         : combinational one-hot grant (zero when nobody eligible)
//   o_mem_addr    : registered address to instruction memory
//   o_mem_en      : stage-1 slot holds a live request
//   i_mem_rdata   : combinational memory read data for o_mem_addr
//   o_rsp_valid   : registered one-hot response strobe
//   o_rsp_rdata   : registered instruction word (zero on misaligned fetch)
//   o_rsp_err     : registered misaligned-address flag
module imem_fetch_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = $clog2(NUM_CORES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    i_req,
  input  logic [NUM_CORES*32-1:0] i_req_addr,
  input  logic [NUM_CORES-1:0]    i_flush,
  output logic [NUM_CORES-1:0]    o_gnt,
  output logic [31:0]             o_mem_addr,
  output logic                    o_mem_en,
  input  logic [31:0]             i_mem_rdata,
  output logic [NUM_CORES-1:0]    o_rsp_valid,
  output logic [31:0]             o_rsp_rdata,
  output logic                    o_rsp_err
);

  localparam logic [ID_W:0]   NC   = (ID_W+1)'(NUM_CORES);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_CORES - 1);

  logic [ID_W-1:0]      r_rr_ptr;
  logic                 r_vld_p1;
  logic [ID_W-1:0]      r_owner_p1;
  logic                 r_err_p1;
  logic [31:0]          r_addr_p1;
  logic [NUM_CORES-1:0] r_vld_p2;
  logic [31:0]          r_rdata_p2;
  logic                 r_err_p2;

  logic [NUM_CORES-1:0] w_elig;
  logic [ID_W:0]        w_idx;
  logic                 w_any;
  logic [ID_W-1:0]      w_win;
  logic [31:0]          w_win_addr;
  logic                 w_rsp_vld;

  // Misaligned fetches return a zero word so garbage never reaches decode.
  function automatic logic [31:0] f_rsp_data(input logic err, input logic [31:0] rdata);
    return err ? 32'h0 : rdata;
  endfunction

  // Stage p0: round-robin pick of the first eligible core at or after r_rr_ptr.
  always_comb begin
    w_elig = i_req & ~i_flush;
    w_any  = 1'b0;
    w_win  = '0;
    w_idx  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= NC) w_idx = w_idx - NC;
      if (!w_any && w_elig[w_idx[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[ID_W-1:0];
      end
    end
  end

  assign o_gnt      = w_any ? (NUM_CORES'(1) << w_win) : '0;
  assign w_win_addr = i_req_addr[{w_win, 5'b0} +: 32];

  // A flush aimed at the stage-1 owner drops the entry before it responds.
  assign w_rsp_vld  = r_vld_p1 && !i_flush[r_owner_p1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_vld_p1   <= 1'b0;
      r_owner_p1 <= '0;
      r_err_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_vld_p2   <= '0;
      r_rdata_p2 <= '0;
      r_err_p2   <= 1'b0;
    end else begin
      // Stage p1: capture the winner; address holds when idle.
      r_vld_p1 <= w_any;
      if (w_any) begin
        r_rr_ptr   <= (w_win == LAST) ? '0 : w_win + ID_W'(1);
        r_addr_p1  <= w_win_addr;
        r_owner_p1 <= w_win;
        r_err_p1   <= |w_win_addr[1:0];
      end
      // Stage p2: response; data/err hold while no strobe is issued.
      r_vld_p2 <= w_rsp_vld ? (NUM_CORES'(1) << r_owner_p1) : '0;
      if (w_rsp_vld) begin
        r_rdata_p2 <= f_rsp_data(r_err_p1, i_mem_rdata);
        r_err_p2   <= r_err_p1;
      end
    end
  end

  assign o_mem_addr  = r_addr_p1;
  assign o_mem_en    = r_vld_p1;
  assign o_rsp_valid = r_vld_p2;
  assign o_rsp_rdata = r_rdata_p2;
  assign o_rsp_err   = r_err_p2;

endmodule
